// File: rtl/tap_hs_cdc_rx.sv
// tap_hs_cdc_rx: receive side of a 4-phase req/ack clock-domain crossing.
// The asynchronous request passes through a reset-to-zero flop chain. A
// synchronized request captures the source-held data bus into a single-entry
// buffer, and a registered acknowledge goes back to the source domain. The
// acknowledge falls only after the request drops and the buffer is empty, so
// an unconsumed word can never be overwritten.
module tap_hs_cdc_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ck,
    input  logic             rb,
    input  logic             req_async,
    input  logic [WIDTH-1:0] data_async,
    output logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACK_HI = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    logic                   consume_s;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic                   ack_r;
    logic                   ack_nx_s;
    logic [WIDTH-1:0]       dout_r;
    logic [WIDTH-1:0]       dout_nx_s;
    logic                   vld_r;
    logic                   vld_nx_s;
    logic                   busy_r;
    logic                   busy_nx_s;

    // Only the last synchronizer stage is used downstream.
    assign req_s     = sync_r[SYNC_STAGES-1];
    assign consume_s = vld_r & dout_rdy;

    // Request synchronizer chain; every stage clears on reset.
    always_ff @(posedge ck or negedge rb) begin
        if (!rb) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_async};
        end
    end

    // Next-state logic: capture from IDLE, release ack once req drops and the buffer drains.
    always_comb begin
        state_nx_s = state_r;
        ack_nx_s   = ack_r;
        dout_nx_s  = dout_r;
        vld_nx_s   = vld_r & ~consume_s;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    dout_nx_s  = data_async;
                    vld_nx_s   = 1'b1;
                    ack_nx_s   = 1'b1;
                    state_nx_s = ST_ACK_HI;
                end else begin
                    ack_nx_s   = 1'b0;
                end
            end
            ST_ACK_HI: begin
                if (!req_s && (!vld_r || consume_s)) begin
                    ack_nx_s   = 1'b0;
                    state_nx_s = ST_IDLE;
                end else begin
                    ack_nx_s   = 1'b1;
                end
            end
            default: begin
                ack_nx_s   = 1'b0;
                vld_nx_s   = 1'b0;
                state_nx_s = ST_IDLE;
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE) | vld_nx_s;
    end

    // State, output buffer and handshake registers.
    always_ff @(posedge ck or negedge rb) begin
        if (!rb) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
            dout_r  <= '0;
            vld_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ack_r   <= ack_nx_s;
            dout_r  <= dout_nx_s;
            vld_r   <= vld_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    assign ack      = ack_r;
    assign dout     = dout_r;
    assign dout_vld = vld_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_tap_hs_cdc_rx.sv
// Directed bench for tap_hs_cdc_rx (WIDTH=8, SYNC_STAGES=2).
module tb_tap_hs_cdc_rx;

    logic       ck;
    logic       rb;
    logic       req_async;
    logic [7:0] data_async;
    logic       ack;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       busy;

    int vec_cnt;
    int err_cnt;

    logic [7:0] rx_q[$];
    bit         stream_done;

    tap_hs_cdc_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .ck         (ck),
        .rb         (rb),
        .req_async  (req_async),
        .data_async (data_async),
        .ack        (ack),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .dout_rdy   (dout_rdy),
        .busy       (busy)
    );

    // 10-unit receive clock.
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic a, input logic v,
                              input logic [7:0] d, input logic b);
        check_val({tag, ".ack"}, {63'd0, ack}, {63'd0, a});
        check_val({tag, ".vld"}, {63'd0, dout_vld}, {63'd0, v});
        check_val({tag, ".dout"}, {56'd0, dout}, {56'd0, d});
        check_val({tag, ".busy"}, {63'd0, busy}, {63'd0, b});
    endtask

    // Wait up to a bound for ack to reach a level; expiry is a failed comparison.
    task automatic wait_ack(input string tag, input logic lvl);
        int n;
        n = 0;
        while (ack !== lvl && n < 200) begin
            tick();
            n++;
        end
        check_val({tag, ".ack_wait"}, {63'd0, ack}, {63'd0, lvl});
    endtask

    task automatic source_stream();
        for (int i = 0; i < 16; i++) begin
            data_async = i[7:0];
            repeat ($urandom_range(0, 3)) tick();
            req_async = 1'b1;
            wait_ack("stream_hi", 1'b1);
            repeat ($urandom_range(0, 3)) tick();
            req_async = 1'b0;
            wait_ack("stream_lo", 1'b0);
        end
    endtask

    task automatic sink_stream();
        int cyc;
        cyc = 0;
        while (!stream_done && cyc < 4000) begin
            dout_rdy = 1'($urandom_range(0, 1));
            @(negedge ck);
            if (dout_vld && dout_rdy) rx_q.push_back(dout);
            tick();
            cyc++;
        end
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        stream_done = 1'b0;

        // Reset with a request already pending.
        rb         = 1'b0;
        req_async  = 1'b1;
        data_async = 8'hA5;
        dout_rdy   = 1'b0;
        tick();
        check_outs("rst0", 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check_outs("rst1", 1'b0, 1'b0, 8'h00, 1'b0);
        rb = 1'b1;
        repeat (3) tick();
        check_outs("rst_cap", 1'b1, 1'b1, 8'hA5, 1'b1);
        req_async = 1'b0;
        dout_rdy  = 1'b1;
        tick();
        check_val("rst_consume.vld", {63'd0, dout_vld}, 64'd0);
        wait_ack("rst_done", 1'b0);
        tick();

        // Single transfer with dout_rdy high.
        req_async  = 1'b1;
        data_async = 8'h3C;
        tick();
        tick();
        check_outs("single_pre", 1'b0, 1'b0, 8'hA5, 1'b0);
        tick();
        check_outs("single_cap", 1'b1, 1'b1, 8'h3C, 1'b1);
        tick();
        check_outs("single_cons", 1'b1, 1'b0, 8'h3C, 1'b1);
        repeat (4) tick();
        req_async = 1'b0;
        tick();
        tick();
        check_val("single_fall_pre.ack", {63'd0, ack}, 64'd1);
        tick();
        check_outs("single_fall", 1'b0, 1'b0, 8'h3C, 1'b0);

        // Back-pressure: req drops while the word is unconsumed.
        dout_rdy   = 1'b0;
        req_async  = 1'b1;
        data_async = 8'h5A;
        repeat (3) tick();
        check_outs("bp_cap", 1'b1, 1'b1, 8'h5A, 1'b1);
        req_async  = 1'b0;
        data_async = 8'hFF;
        repeat (6) tick();
        check_outs("bp_hold", 1'b1, 1'b1, 8'h5A, 1'b1);
        dout_rdy = 1'b1;
        tick();
        check_outs("bp_drain", 1'b0, 1'b0, 8'h5A, 1'b0);

        // Stream of 16 words with random back-pressure and handshake delays.
        fork
            begin
                source_stream();
                repeat (4) tick();
                stream_done = 1'b1;
            end
            sink_stream();
        join
        dout_rdy = 1'b1;
        check_val("stream_count", 64'(rx_q.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx_q.size()) check_val($sformatf("stream_w%0d", i), {56'd0, rx_q[i]}, 64'(i));
        end
        tick();

        // Mid-operation reset while holding a word in ACK_HI.
        dout_rdy   = 1'b0;
        req_async  = 1'b1;
        data_async = 8'h77;
        repeat (3) tick();
        check_outs("mid_cap", 1'b1, 1'b1, 8'h77, 1'b1);
        @(negedge ck);
        rb = 1'b0;
        #1;
        check_outs("mid_rst", 1'b0, 1'b0, 8'h00, 1'b0);
        req_async = 1'b0;
        tick();
        rb = 1'b1;
        repeat (5) tick();
        check_outs("mid_post", 1'b0, 1'b0, 8'h00, 1'b0);

        // One-cycle request pulse caught by sync[0].
        dout_rdy   = 1'b1;
        data_async = 8'hC3;
        req_async  = 1'b1;
        tick();
        req_async = 1'b0;
        tick();
        check_outs("pulse_pre", 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check_outs("pulse_cap", 1'b1, 1'b1, 8'hC3, 1'b1);
        tick();
        check_outs("pulse_end", 1'b0, 1'b0, 8'hC3, 1'b0);
        repeat (5) tick();
        check_outs("pulse_quiet", 1'b0, 1'b0, 8'hC3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
